// File: rtl/lzrw1_pkg.sv
// Shared LZRW1 definitions: output FIFO geometry and the stored word format.
package lzrw1_pkg;

    localparam int OFIFO_DEPTH       = 512;
    localparam int OFIFO_ADR_BIT_LEN = 9;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  count;
    } ofifo_entry_t;

endpackage

// File: rtl/ofifo_word_ram.sv
// Simple dual-port word RAM for the output FIFO: one write port, one synchronous read port.
module ofifo_word_ram #(
    parameter int DEPTH       = 512,
    parameter int ADR_BIT_LEN = 9,
    parameter int WIDTH       = 35
) (
    input  logic                   ClkxCI,
    input  logic                   WExSI,
    input  logic [ADR_BIT_LEN-1:0] WrAdrxDI,
    input  logic [WIDTH-1:0]       WrDataxDI,
    input  logic                   RExSI,
    input  logic [ADR_BIT_LEN-1:0] RdAdrxDI,
    output logic [WIDTH-1:0]       RdDataxDO
);

    logic [WIDTH-1:0] MemxDP [DEPTH];

    // Write port
    always_ff @(posedge ClkxCI) begin
        if (WExSI) begin
            MemxDP[WrAdrxDI] <= WrDataxDI;
        end
    end

    // Registered read port
    always_ff @(posedge ClkxCI) begin
        if (RExSI) begin
            RdDataxDO <= MemxDP[RdAdrxDI];
        end
    end

endmodule

// File: rtl/output_fifo.sv
// Output FIFO: packs encoder bytes into 32-bit words and buffers them first-word-fall-through.
module output_fifo
    import lzrw1_pkg::*;
#(
    parameter int DEPTH       = OFIFO_DEPTH,
    parameter int ADR_BIT_LEN = OFIFO_ADR_BIT_LEN
) (
    input  logic                   ClkxCI,
    input  logic                   RstxRBI,
    input  logic [7:0]             DInxDI,
    input  logic                   WExSI,
    input  logic                   FlushxSI,
    input  logic                   ReadxSI,
    output logic [31:0]            DOutxDO,
    output logic [2:0]             ValidBytesxDO,
    output logic                   ValidxSO,
    output logic [ADR_BIT_LEN:0]   LevelxDO,
    output logic                   FullxSO,
    output logic                   OverflowxSO
);

    localparam logic [ADR_BIT_LEN:0]   DEPTH_L  = (ADR_BIT_LEN+1)'(DEPTH);
    localparam logic [ADR_BIT_LEN:0]   FULL_THR = (ADR_BIT_LEN+1)'(DEPTH - 2);
    localparam logic [ADR_BIT_LEN:0]   CNT_ONE  = (ADR_BIT_LEN+1)'(1);
    localparam logic [ADR_BIT_LEN-1:0] PTR_ONE  = ADR_BIT_LEN'(1);

    logic [1:0]             ByteCntxDP;
    logic [23:0]            PartialxDP;
    logic [ADR_BIT_LEN-1:0] WrPtrxDP, RdPtrxDP;
    logic [ADR_BIT_LEN:0]   RamCntxDP, LevelxDP, LevelxDN;
    logic                   RamQValidxDP, ValidxDP, FullxDP, OverflowxDP;
    logic [31:0]            DOutxDP;
    logic [2:0]             ValidBytesxDP;

    logic [31:0]            PackedxS;
    logic [2:0]             CntAfterxS;
    logic                   PushReqxS, PushAccxS, PopxS, LoadxS, RdEnxS;
    ofifo_entry_t           WrEntryxS, RamQxS;
    logic [$bits(ofifo_entry_t)-1:0] RamQRawxS;

    // Byte packer: drop the new byte into its lane and decide whether a word leaves
    always_comb begin
        PackedxS   = {8'h00, PartialxDP};
        CntAfterxS = {1'b0, ByteCntxDP} + {2'b00, WExSI};
        if (WExSI) begin
            PackedxS[{ByteCntxDP, 3'b000} +: 8] = DInxDI;
        end else begin
            PackedxS = {8'h00, PartialxDP};
        end
        PushReqxS = (CntAfterxS == 3'd4) || (FlushxSI && (CntAfterxS != 3'd0));
        WrEntryxS = '{data: PackedxS, count: CntAfterxS};
    end

    // Push/pop handshakes; the RAM prefetches into its read register ahead of the output stage
    always_comb begin
        PopxS     = ReadxSI && ValidxDP;
        PushAccxS = PushReqxS && ((LevelxDP < DEPTH_L) || PopxS);
        LoadxS    = RamQValidxDP && (!ValidxDP || PopxS);
        RdEnxS    = (RamCntxDP != '0) && (!RamQValidxDP || LoadxS);
        RamQxS    = ofifo_entry_t'(RamQRawxS);
        case ({PushAccxS, PopxS})
            2'b10:   LevelxDN = LevelxDP + CNT_ONE;
            2'b01:   LevelxDN = LevelxDP - CNT_ONE;
            default: LevelxDN = LevelxDP;
        endcase
    end

    // Packer state; any emitted word (even a dropped one) restarts at lane 0
    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            ByteCntxDP <= 2'd0;
            PartialxDP <= 24'h000000;
        end else if (PushReqxS) begin
            ByteCntxDP <= 2'd0;
            PartialxDP <= 24'h000000;
        end else begin
            ByteCntxDP <= CntAfterxS[1:0];
            PartialxDP <= PackedxS[23:0];
        end
    end

    // Pointers, occupancy and status flags
    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            WrPtrxDP    <= '0;
            RdPtrxDP    <= '0;
            RamCntxDP   <= '0;
            LevelxDP    <= '0;
            FullxDP     <= 1'b0;
            OverflowxDP <= 1'b0;
        end else begin
            WrPtrxDP    <= PushAccxS ? WrPtrxDP + PTR_ONE : WrPtrxDP;
            RdPtrxDP    <= RdEnxS ? RdPtrxDP + PTR_ONE : RdPtrxDP;
            RamCntxDP   <= RamCntxDP + (PushAccxS ? CNT_ONE : '0) - (RdEnxS ? CNT_ONE : '0);
            LevelxDP    <= LevelxDN;
            FullxDP     <= (LevelxDN >= FULL_THR);
            OverflowxDP <= OverflowxDP || (PushReqxS && !PushAccxS);
        end
    end

    // Read register occupancy and output stage
    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            RamQValidxDP  <= 1'b0;
            ValidxDP      <= 1'b0;
            DOutxDP       <= 32'h0000_0000;
            ValidBytesxDP <= 3'd0;
        end else begin
            if (RdEnxS) begin
                RamQValidxDP <= 1'b1;
            end else if (LoadxS) begin
                RamQValidxDP <= 1'b0;
            end else begin
                RamQValidxDP <= RamQValidxDP;
            end
            if (LoadxS) begin
                ValidxDP      <= 1'b1;
                DOutxDP       <= RamQxS.data;
                ValidBytesxDP <= RamQxS.count;
            end else if (PopxS) begin
                ValidxDP      <= 1'b0;
            end else begin
                ValidxDP      <= ValidxDP;
            end
        end
    end

    ofifo_word_ram #(
        .DEPTH      (DEPTH),
        .ADR_BIT_LEN(ADR_BIT_LEN),
        .WIDTH      ($bits(ofifo_entry_t))
    ) u_ram (
        .ClkxCI   (ClkxCI),
        .WExSI    (PushAccxS),
        .WrAdrxDI (WrPtrxDP),
        .WrDataxDI(WrEntryxS),
        .RExSI    (RdEnxS),
        .RdAdrxDI (RdPtrxDP),
        .RdDataxDO(RamQRawxS)
    );

    assign DOutxDO       = DOutxDP;
    assign ValidBytesxDO = ValidBytesxDP;
    assign ValidxSO      = ValidxDP;
    assign LevelxDO      = LevelxDP;
    assign FullxSO       = FullxDP;
    assign OverflowxSO   = OverflowxDP;

endmodule

// File: tb/tb_output_fifo.sv
// Directed bench for output_fifo: vector table for packing/flush cases, hand sequences for full/wrap, streaming and reset.
module tb_output_fifo;

    localparam int DEPTH = 8;
    localparam int ADR   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        we, flush, rd;
    logic [31:0] dout;
    logic [2:0]  vb;
    logic        valid, full, ovf;
    logic [ADR:0] level;

    int nvec = 0;
    int nerr = 0;

    output_fifo #(.DEPTH(DEPTH), .ADR_BIT_LEN(ADR)) dut (
        .ClkxCI(clk), .RstxRBI(rst_n), .DInxDI(din), .WExSI(we), .FlushxSI(flush),
        .ReadxSI(rd), .DOutxDO(dout), .ValidBytesxDO(vb), .ValidxSO(valid),
        .LevelxDO(level), .FullxSO(full), .OverflowxSO(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  din;
        logic        flush;
        logic        rd;
        logic        valid;
        logic [31:0] dout;
        logic [2:0]  vb;
        logic [3:0]  level;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic w, logic [7:0] d, logic f, logic r,
                                logic v, logic [31:0] o, logic [2:0] b, logic [3:0] l);
        vec_t t;
        t.we = w; t.din = d; t.flush = f; t.rd = r;
        t.valid = v; t.dout = o; t.vb = b; t.level = l;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            we  = 1'b1;
            din = w[8*b +: 8];
            @(posedge clk);
        end
        #2;
        we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] wexp [9];
        logic [31:0] sexp [6];
        int idx;
        int maxlvl;

        rst_n = 1'b0; we = 1'b0; flush = 1'b0; rd = 1'b0; din = 8'h00;
        #23;
        check("reset_outputs", {32'h0, dout, vb, valid, level, full, ovf}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // we, din, flush, rd | valid, dout, vb, level
        vecs.push_back(mk(1, 8'h11, 0, 0, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'h22, 0, 0, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'h33, 0, 0, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'h44, 0, 0, 0, 32'h0, 3'd0, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0, 3'd0, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 32'h44332211, 3'd4, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 32'h44332211, 3'd4, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'hAA, 0, 0, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'hBB, 0, 0, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 32'h0, 3'd0, 4'd1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 32'h0, 3'd0, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 32'h0000BBAA, 3'd2, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'h01, 0, 0, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'h02, 0, 0, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'h03, 0, 0, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'h04, 1, 0, 0, 32'h0, 3'd0, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0, 3'd0, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 32'h04030201, 3'd4, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'h5A, 1, 0, 0, 32'h0, 3'd0, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0, 3'd0, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 32'h0000005A, 3'd1, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'hC1, 0, 0, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'hC2, 0, 0, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(1, 8'hC3, 0, 0, 0, 32'h0, 3'd0, 4'd0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 32'h0, 3'd0, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0, 3'd0, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 32'h00C3C2C1, 3'd3, 4'd1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0, 3'd0, 4'd0));

        foreach (vecs[i]) begin
            @(negedge clk);
            we = vecs[i].we; din = vecs[i].din; flush = vecs[i].flush; rd = vecs[i].rd;
            @(posedge clk);
            #2;
            if (vecs[i].valid)
                check($sformatf("vec%0d", i), {25'h0, dout, vb, valid, level, full, ovf},
                      {25'h0, vecs[i].dout, vecs[i].vb, 1'b1, vecs[i].level, 1'b0, 1'b0});
            else
                check($sformatf("vec%0d", i), {57'h0, valid, level, full, ovf},
                      {57'h0, 1'b0, vecs[i].level, 1'b0, 1'b0});
        end
        @(negedge clk);
        we = 1'b0; flush = 1'b0; rd = 1'b0;

        // Fill past capacity with no reads; write pointer wraps during this
        for (int j = 0; j < 9; j++) begin
            int el;
            wexp[j] = 32'h03020100 + 32'h04040404 * j;
            write_word(wexp[j]);
            el = (j + 1 > DEPTH) ? DEPTH : j + 1;
            check($sformatf("fill%0d_level", j), {60'h0, level}, 64'(el));
            check($sformatf("fill%0d_full", j), {63'h0, full}, {63'h0, el >= DEPTH - 2});
            check($sformatf("fill%0d_ovf", j), {63'h0, ovf}, {63'h0, j == 8});
        end

        // Drain with read held high; order must match the first DEPTH words
        @(negedge clk);
        rd  = 1'b1;
        idx = 0;
        for (int c = 0; c < 60 && idx < DEPTH; c++) begin
            if (valid) begin
                check($sformatf("drain%0d", idx), {32'h0, dout}, {32'h0, wexp[idx]});
                idx++;
            end
            @(negedge clk);
        end
        check("drain_count", 64'(idx), 64'(DEPTH));
        @(negedge clk);
        check("drain_empty", {59'h0, valid, level}, 64'h0);
        check("ovf_sticky", {63'h0, ovf}, 64'h1);

        // Streaming: bytes every cycle, consumer always ready
        for (int j = 0; j < 6; j++) sexp[j] = 32'h44332211 + 32'h01010101 * j;
        idx = 0;
        maxlvl = 0;
        fork
            begin
                for (int j = 0; j < 6; j++) write_word(sexp[j]);
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (int'(level) > maxlvl) maxlvl = int'(level);
                    if (valid) begin
                        if (idx < 6)
                            check($sformatf("stream%0d", idx), {29'h0, dout, vb}, {29'h0, sexp[idx], 3'd4});
                        idx++;
                    end
                end
            end
        join
        check("stream_count", 64'(idx), 64'd6);
        check("stream_level_bound", {63'h0, maxlvl <= 3}, 64'h1);
        rd = 1'b0;

        // Reset in the middle of a partial word
        @(negedge clk);
        we = 1'b1; din = 8'hE1;
        @(negedge clk);
        din = 8'hE2;
        @(posedge clk);
        #2;
        we = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {32'h0, dout, vb, valid, level, full, ovf}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        write_word(32'h8D7C6B5A);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("after_reset_word", {21'h0, dout, vb, valid, level, ovf},
              {21'h0, 32'h8D7C6B5A, 3'd4, 1'b1, 4'd1, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
